// File: rtl/micro_tile_selector.sv
// Debounced tile-select front end: synchronises and debounces the raw select pins,
// then performs a gated, reset-held handover to the newly selected tile.
module micro_tile_selector #(
    parameter int SEL_W           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             ext_rst_n,
    output logic [SEL_W-1:0] sel,
    output logic             tile_clk_en,
    output logic             tile_rst_n,
    output logic             switching,
    output logic [7:0]       switch_count
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN,
        GATE,
        SWAP,
        HOLD
    } state_t;

    logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_q;
    logic [SEL_W-1:0]  req_s;
    logic [SEL_W-1:0]  req_prev;
    logic [SEL_W-1:0]  stable_sel;
    logic [DB_W-1:0]   db_cnt;
    logic              db_cond;

    state_t            state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [SEL_W-1:0]  sel_d;
    logic              tile_clk_en_d;
    logic              tile_rst_n_d;
    logic              switching_d;
    logic [7:0]        switch_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_sel};
        end
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign db_cond = (req_s != stable_sel) && (req_s == req_prev);

    // A new value is accepted only after it has stayed put for DEBOUNCE_CYCLES
    // consecutive comparisons against its own previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev   <= '0;
            stable_sel <= '0;
            db_cnt     <= '0;
        end else begin
            req_prev <= req_s;
            if (db_cond) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_sel <= req_s;
                    db_cnt     <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        case (state)
            RUN:  if (stable_sel != sel) state_d = GATE;
            GATE: state_d = SWAP;
            SWAP: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so
    // sel can only move on the edge that enters SWAP, when the clock is already gated.
    always_comb begin
        sel_d          = sel;
        switch_count_d = switch_count;
        tile_clk_en_d  = 1'b1;
        tile_rst_n_d   = 1'b0;
        switching_d    = 1'b1;
        case (state_d)
            RUN: begin
                tile_rst_n_d = ext_rst_n;
                switching_d  = 1'b0;
            end
            GATE: tile_clk_en_d = 1'b0;
            SWAP: begin
                tile_clk_en_d = 1'b0;
                sel_d         = stable_sel;
                if (switch_count != 8'hFF) switch_count_d = switch_count + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            sel          <= '0;
            tile_clk_en  <= 1'b1;
            tile_rst_n   <= 1'b0;
            switching    <= 1'b1;
            switch_count <= 8'd0;
        end else begin
            state        <= state_d;
            hold_cnt     <= hold_cnt_d;
            sel          <= sel_d;
            tile_clk_en  <= tile_clk_en_d;
            tile_rst_n   <= tile_rst_n_d;
            switching    <= switching_d;
            switch_count <= switch_count_d;
        end
    end

endmodule
